// File: rtl/nibble_assembler.sv
// Collects two 4-bit nibbles over valid/ready, merges them through the external
// nibble shifter into one byte and presents that byte downstream with valid/ready.
module nibble_assembler #(
    parameter int HIGH_FIRST = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nibIN,
    input  logic       nibValid,
    output logic       nibReady,
    output logic [3:0] shNib,
    output logic       shSel,
    input  logic [7:0] shData,
    input  logic       clear,
    output logic [7:0] byteOUT,
    output logic       byteValid,
    input  logic       byteReady,
    output logic       timeoutErr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT2 = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic       FIRST_SEL = (HIGH_FIRST != 0);
    localparam logic [7:0] LAST_CNT  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] acc;
    logic [7:0] cnt;
    logic [7:0] first_part;
    logic       accept;

    assign nibReady = ((state == IDLE) || (state == WAIT2)) && !clear;
    assign accept   = nibValid && nibReady;
    assign shNib    = nibIN;
    assign shSel    = (state == IDLE) ? FIRST_SEL : ~FIRST_SEL;

    // The half of the shifter result not selected is forced to zero before it lands in acc.
    assign first_part = FIRST_SEL ? {shData[7:4], 4'h0} : {4'h0, shData[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            byteOUT    <= '0;
            byteValid  <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            timeoutErr <= 1'b0;
            if (clear) begin
                state     <= IDLE;
                acc       <= '0;
                cnt       <= '0;
                byteValid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            acc   <= first_part;
                            cnt   <= '0;
                            state <= WAIT2;
                        end
                    end
                    WAIT2: begin
                        // A second nibble in the last allowed cycle beats the timeout.
                        if (accept) begin
                            byteOUT   <= acc | shData;
                            byteValid <= 1'b1;
                            state     <= FULL;
                        end else if (TIMEOUT != 0) begin
                            if (cnt == LAST_CNT) begin
                                state      <= IDLE;
                                acc        <= '0;
                                cnt        <= '0;
                                timeoutErr <= 1'b1;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    FULL: begin
                        if (byteReady) begin
                            byteValid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nibble_assembler.sv
// Directed bench for nibble_assembler: one instance with HIGH_FIRST=1/TIMEOUT=4 and one
// with HIGH_FIRST=0/TIMEOUT=0 share stimulus; each has its own behavioural shifter.
module tb_nibble_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nib = 4'h0;
    logic       nv  = 1'b0;
    logic       br  = 1'b0;
    logic       clr = 1'b0;

    logic       rdy1, sel1, bv1, te1;
    logic [3:0] shn1;
    logic [7:0] shd1, bo1;
    logic       rdy0, sel0, bv0, te0;
    logic [3:0] shn0;
    logic [7:0] shd0, bo0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign shd1 = sel1 ? {shn1, 4'h0} : {4'h0, shn1};
    assign shd0 = sel0 ? {shn0, 4'h0} : {4'h0, shn0};

    nibble_assembler #(.HIGH_FIRST(1), .TIMEOUT(4)) u1 (
        .clk(clk), .rst(rst), .nibIN(nib), .nibValid(nv), .nibReady(rdy1),
        .shNib(shn1), .shSel(sel1), .shData(shd1), .clear(clr),
        .byteOUT(bo1), .byteValid(bv1), .byteReady(br), .timeoutErr(te1)
    );

    nibble_assembler #(.HIGH_FIRST(0), .TIMEOUT(0)) u0 (
        .clk(clk), .rst(rst), .nibIN(nib), .nibValid(nv), .nibReady(rdy0),
        .shNib(shn0), .shSel(sel0), .shData(shd0), .clear(clr),
        .byteOUT(bo0), .byteValid(bv0), .byteReady(br), .timeoutErr(te0)
    );

    typedef struct {
        logic [3:0] nib;
        logic       nv;
        logic       br;
        logic       clr;
        logic       er;
        logic       es;
        logic       ev;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] swp(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic v, input logic b, input logic c);
        nib = n; nv = v; br = b; clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // nib nv br clr | pre-edge ready, u1 sel | post-edge valid, u1 byte
        tbl.push_back('{4'hA, 1, 1, 0, 1, 1, 0, 8'h00});
        tbl.push_back('{4'h5, 1, 1, 0, 1, 0, 1, 8'hA5});
        tbl.push_back('{4'h0, 0, 1, 0, 0, 0, 0, 8'hA5});
        tbl.push_back('{4'h0, 0, 1, 0, 1, 1, 0, 8'hA5});
        tbl.push_back('{4'h3, 1, 0, 0, 1, 1, 0, 8'hA5});
        tbl.push_back('{4'hC, 1, 0, 0, 1, 0, 1, 8'h3C});
        for (int k = 0; k < 5; k++) tbl.push_back('{4'hF, 1, 0, 0, 0, 0, 1, 8'h3C});
        tbl.push_back('{4'hF, 1, 1, 0, 0, 0, 0, 8'h3C});
        tbl.push_back('{4'h1, 1, 1, 0, 1, 1, 0, 8'h3C});
        tbl.push_back('{4'h2, 1, 1, 0, 1, 0, 1, 8'h12});
        tbl.push_back('{4'h0, 0, 1, 0, 0, 0, 0, 8'h12});
        tbl.push_back('{4'h9, 1, 1, 0, 1, 1, 0, 8'h12});
        tbl.push_back('{4'h9, 0, 1, 1, 0, 0, 0, 8'h12});
        tbl.push_back('{4'h1, 1, 1, 0, 1, 1, 0, 8'h12});
        tbl.push_back('{4'h1, 1, 0, 0, 1, 0, 1, 8'h11});
        tbl.push_back('{4'h0, 0, 0, 1, 0, 0, 0, 8'h11});
        tbl.push_back('{4'h0, 0, 0, 0, 1, 1, 0, 8'h11});
        tbl.push_back('{4'h4, 1, 0, 1, 0, 1, 0, 8'h11});
        tbl.push_back('{4'h0, 0, 0, 0, 1, 1, 0, 8'h11});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bv1", {7'd0, bv1}, 8'h00);
        chk("rst_bo1", bo1, 8'h00);
        chk("rst_te1", {7'd0, te1}, 8'h00);
        chk("rst_rdy1", {7'd0, rdy1}, 8'h01);
        chk("rst_sel1", {7'd0, sel1}, 8'h01);
        chk("rst_sel0", {7'd0, sel0}, 8'h00);
        chk("rst_bo0", bo0, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].nib, tbl[i].nv, tbl[i].br, tbl[i].clr);
            chk($sformatf("v%0d_rdy1", i), {7'd0, rdy1}, {7'd0, tbl[i].er});
            chk($sformatf("v%0d_rdy0", i), {7'd0, rdy0}, {7'd0, tbl[i].er});
            chk($sformatf("v%0d_sel1", i), {7'd0, sel1}, {7'd0, tbl[i].es});
            chk($sformatf("v%0d_sel0", i), {7'd0, sel0}, {7'd0, ~tbl[i].es});
            tick();
            chk($sformatf("v%0d_bv1", i), {7'd0, bv1}, {7'd0, tbl[i].ev});
            chk($sformatf("v%0d_bv0", i), {7'd0, bv0}, {7'd0, tbl[i].ev});
            chk($sformatf("v%0d_bo1", i), bo1, tbl[i].eb);
            chk($sformatf("v%0d_bo0", i), bo0, swp(tbl[i].eb));
            chk($sformatf("v%0d_te1", i), {7'd0, te1}, 8'h00);
        end

        // Accumulator contents after the first nibble
        drive(4'hA, 1, 1, 0);
        tick();
        chk("acc_u0", u0.acc, 8'h0A);
        chk("acc_u1", u1.acc, 8'hA0);
        drive(4'h0, 0, 1, 1);
        tick();

        // Timeout expiry on u1 (TIMEOUT=4); u0 has the timeout disabled
        drive(4'h7, 1, 1, 0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(4'h0, 0, 1, 0);
            tick();
            chk($sformatf("to_te1_c%0d", k), {7'd0, te1}, (k == 4) ? 8'h01 : 8'h00);
            chk($sformatf("to_te0_c%0d", k), {7'd0, te0}, 8'h00);
        end
        drive(4'h0, 0, 1, 0);
        chk("to_sel1_idle", {7'd0, sel1}, 8'h01);
        chk("to_sel0_wait2", {7'd0, sel0}, 8'h01);
        drive(4'h0, 0, 1, 1);
        tick();

        // Second nibble in the last allowed cycle wins over the timeout
        drive(4'h7, 1, 1, 0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            drive(4'h0, 0, 0, 0);
            tick();
            chk($sformatf("win_te1_c%0d", k), {7'd0, te1}, 8'h00);
        end
        drive(4'h8, 1, 0, 0);
        tick();
        chk("win_te1", {7'd0, te1}, 8'h00);
        chk("win_bv1", {7'd0, bv1}, 8'h01);
        chk("win_bo1", bo1, 8'h78);
        chk("win_bo0", bo0, 8'h87);
        drive(4'h0, 0, 1, 0);
        tick();
        chk("win_te1_after", {7'd0, te1}, 8'h00);
        chk("win_bv1_drain", {7'd0, bv1}, 8'h00);

        // Asynchronous reset while a byte is held in FULL
        drive(4'hA, 1, 0, 0);
        tick();
        drive(4'h5, 1, 0, 0);
        tick();
        chk("ar_bv1_full", {7'd0, bv1}, 8'h01);
        drive(4'h0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_bv1", {7'd0, bv1}, 8'h00);
        chk("ar_bo1", bo1, 8'h00);
        chk("ar_te1", {7'd0, te1}, 8'h00);
        chk("ar_bv0", {7'd0, bv0}, 8'h00);
        chk("ar_bo0", bo0, 8'h00);
        #2;
        rst = 1'b0;
        tick();
        drive(4'hC, 1, 1, 0);
        chk("ar_rdy1", {7'd0, rdy1}, 8'h01);
        tick();
        drive(4'h3, 1, 1, 0);
        tick();
        chk("ar_bv1_new", {7'd0, bv1}, 8'h01);
        chk("ar_bo1_new", bo1, 8'hC3);
        chk("ar_bo0_new", bo0, 8'h3C);
        drive(4'h0, 0, 1, 0);
        tick();
        chk("ar_bv1_done", {7'd0, bv1}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
